param_wb_cache: RTL and testbench

PARAM_WB_CACHE -- requirements
Module: param_wb_cache

---
 rtl/cache_types.sv | 25 ++
 rtl/plru_tree.sv | 43 ++++
 rtl/param_wb_cache.sv | 174 +++++++++++++++++
 tb/tb_param_wb_cache.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_types.sv
// Shared types and geometry helpers for the parameterised write-back cache.
package cache_types;

  localparam int unsigned OFFSET_W       = 5;
  localparam int unsigned LINE_BITS      = 256;
  localparam int unsigned WORD_BITS      = 32;
  localparam int unsigned WORDS_PER_LINE = 8;
  localparam int unsigned WORD_SEL_W     = 3;

  typedef enum logic [1:0] {
    IDLE,
    COMPARE,
    WRITEBACK,
    ALLOCATE
  } cache_state_e;

  function automatic int unsigned idx_w(input int unsigned sets);
    return $clog2(sets);
  endfunction

  function automatic int unsigned tag_w(input int unsigned sets);
    return 32 - OFFSET_W - $clog2(sets);
  endfunction

endpackage

// File: rtl/plru_tree.sv
// Tree pseudo-LRU for one set: update on hit and victim walk, purely combinational.
module plru_tree #(
  parameter int unsigned WAYS = 4
) (
  input  logic [WAYS-2:0]         state,
  input  logic [$clog2(WAYS)-1:0] hit_way,
  output logic [WAYS-2:0]         next_state,
  output logic [$clog2(WAYS)-1:0] victim
);

  localparam int unsigned LEVELS = $clog2(WAYS);

  // Heap layout: node n (1-based) owns bit n-1; bit 0 points the victim left, 1 right.
  always_comb begin
    int unsigned node;
    logic [LEVELS-1:0] path;
    logic dir;
    next_state = state;
    node       = 1;
    path       = hit_way;
    dir        = 1'b0;
    for (int unsigned l = 0; l < LEVELS; l++) begin
      dir = path[LEVELS-1];
      next_state[LEVELS'(node - 1)] = ~dir;
      node = 2 * node + {31'b0, dir};
      path = path << 1;
    end
  end

  always_comb begin
    int unsigned vnode;
    logic vdir;
    victim = '0;
    vnode  = 1;
    vdir   = 1'b0;
    for (int unsigned l = 0; l < LEVELS; l++) begin
      vdir   = state[LEVELS'(vnode - 1)];
      victim = (victim << 1) | LEVELS'(vdir);
      vnode  = 2 * vnode + {31'b0, vdir};
    end
  end

endmodule

// File: rtl/param_wb_cache.sv
// Set-associative write-back, write-allocate cache with 32-byte lines and tree-PLRU.
module param_wb_cache
  import cache_types::*;
#(
  parameter int unsigned WAYS = 4,
  parameter int unsigned SETS = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [31:0]          ufp_addr,
  input  logic [3:0]           ufp_rmask,
  input  logic [3:0]           ufp_wmask,
  input  logic [31:0]          ufp_wdata,
  output logic [31:0]          ufp_rdata,
  output logic                 ufp_resp,
  output logic [31:0]          dfp_addr,
  output logic                 dfp_read,
  output logic                 dfp_write,
  output logic [LINE_BITS-1:0] dfp_wdata,
  input  logic [LINE_BITS-1:0] dfp_rdata,
  input  logic                 dfp_resp
);

  localparam int unsigned IDX_W = idx_w(SETS);
  localparam int unsigned TAG_W = tag_w(SETS);
  localparam int unsigned WAY_W = $clog2(WAYS);

  cache_state_e state, state_next;

  logic [TAG_W-1:0]     tag_arr   [SETS][WAYS];
  logic [LINE_BITS-1:0] data_arr  [SETS][WAYS];
  logic [WAYS-1:0]      valid_arr [SETS];
  logic [WAYS-1:0]      dirty_arr [SETS];
  logic [WAYS-2:0]      plru_arr  [SETS];

  logic [TAG_W-1:0]      req_tag;
  logic [IDX_W-1:0]      req_set;
  logic [WORD_SEL_W-1:0] req_word;
  logic [3:0]            req_wmask;
  logic [31:0]           req_wdata;
  logic                  req_write;
  logic [WAY_W-1:0]      victim_q;

  logic                  is_req;
  logic [WAYS-1:0]       hit_vec;
  logic                  hit;
  logic [WAY_W-1:0]      hit_way;
  logic [WAY_W-1:0]      plru_victim;
  logic [WAY_W-1:0]      victim_sel;
  logic [WAYS-2:0]       plru_next;
  logic [LINE_BITS-1:0]  hit_line;
  logic [LINE_BITS-1:0]  merged_line;
  logic                  unused_addr_bits;

  assign is_req           = (|ufp_rmask) || (|ufp_wmask);
  assign unused_addr_bits = ^ufp_addr[1:0];

  always_comb begin
    hit_vec = '0;
    hit_way = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      hit_vec[w] = valid_arr[req_set][w] && (tag_arr[req_set][w] == req_tag);
      if (hit_vec[w]) hit_way = WAY_W'(w);
    end
    hit = |hit_vec;
  end

  // Lowest-index invalid way wins over the PLRU choice.
  always_comb begin
    victim_sel = plru_victim;
    for (int unsigned w = WAYS; w > 0; w--) begin
      if (!valid_arr[req_set][w-1]) victim_sel = WAY_W'(w - 1);
    end
  end

  always_comb begin
    hit_line    = data_arr[req_set][hit_way];
    merged_line = hit_line;
    ufp_rdata   = '0;
    for (int unsigned w = 0; w < WORDS_PER_LINE; w++) begin
      if (WORD_SEL_W'(w) == req_word) begin
        ufp_rdata = hit_line[w*WORD_BITS +: WORD_BITS];
        for (int unsigned b = 0; b < 4; b++) begin
          if (req_wmask[b]) merged_line[w*WORD_BITS + b*8 +: 8] = req_wdata[b*8 +: 8];
        end
      end
    end
  end

  plru_tree #(.WAYS(WAYS)) u_plru (
    .state      (plru_arr[req_set]),
    .hit_way    (hit_way),
    .next_state (plru_next),
    .victim     (plru_victim)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    ufp_resp   = 1'b0;
    dfp_read   = 1'b0;
    dfp_write  = 1'b0;
    dfp_addr   = '0;
    dfp_wdata  = data_arr[req_set][victim_q];
    unique case (state)
      IDLE: begin
        if (is_req) state_next = COMPARE;
      end
      COMPARE: begin
        if (hit) begin
          ufp_resp   = 1'b1;
          state_next = IDLE;
        end else if (valid_arr[req_set][victim_sel] && dirty_arr[req_set][victim_sel]) begin
          state_next = WRITEBACK;
        end else begin
          state_next = ALLOCATE;
        end
      end
      WRITEBACK: begin
        dfp_write = 1'b1;
        dfp_addr  = {tag_arr[req_set][victim_q], req_set, {OFFSET_W{1'b0}}};
        if (dfp_resp) state_next = ALLOCATE;
      end
      ALLOCATE: begin
        dfp_read = 1'b1;
        dfp_addr = {req_tag, req_set, {OFFSET_W{1'b0}}};
        if (dfp_resp) state_next = COMPARE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned s = 0; s < SETS; s++) begin
        valid_arr[s] <= '0;
        dirty_arr[s] <= '0;
        plru_arr[s]  <= '0;
      end
    end else begin
      if (state == COMPARE && hit) begin
        plru_arr[req_set] <= plru_next;
        if (req_write) dirty_arr[req_set][hit_way] <= 1'b1;
      end
      if (state == ALLOCATE && dfp_resp) begin
        valid_arr[req_set][victim_q] <= 1'b1;
        dirty_arr[req_set][victim_q] <= 1'b0;
      end
    end
  end

  // Request fields, victim and line storage carry no reset; all writes are gated by FSM state.
  always_ff @(posedge clk) begin
    if (state == IDLE && is_req) begin
      req_tag   <= ufp_addr[31 -: TAG_W];
      req_set   <= ufp_addr[OFFSET_W +: IDX_W];
      req_word  <= ufp_addr[4:2];
      req_wmask <= ufp_wmask;
      req_wdata <= ufp_wdata;
      req_write <= |ufp_wmask;
    end
    if (state == COMPARE && !hit) victim_q <= victim_sel;
    if (state == COMPARE && hit && req_write) data_arr[req_set][hit_way] <= merged_line;
    if (state == ALLOCATE && dfp_resp) begin
      data_arr[req_set][victim_q] <= dfp_rdata;
      tag_arr[req_set][victim_q]  <= req_tag;
    end
  end

endmodule

// File: tb/tb_param_wb_cache.sv
// Directed bench for param_wb_cache: 4-, 2- and 8-way builds behind a fixed-latency memory.
module tb_param_wb_cache;

  localparam int NDUT    = 3;
  localparam int MEM_LAT = 3;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [NDUT-1:0][31:0]  ufp_addr;
  logic [NDUT-1:0][3:0]   ufp_rmask;
  logic [NDUT-1:0][3:0]   ufp_wmask;
  logic [NDUT-1:0][31:0]  ufp_wdata;
  logic [NDUT-1:0][31:0]  ufp_rdata;
  logic [NDUT-1:0]        ufp_resp;
  logic [NDUT-1:0][31:0]  dfp_addr;
  logic [NDUT-1:0]        dfp_read;
  logic [NDUT-1:0]        dfp_write;
  logic [NDUT-1:0][255:0] dfp_wdata;
  logic [NDUT-1:0][255:0] dfp_rdata;
  logic [NDUT-1:0]        dfp_resp;

  bit          resp_en      [NDUT];
  int          lat_cnt      [NDUT];
  int          rd_cnt       [NDUT];
  int          wr_cnt       [NDUT];
  logic [31:0] last_rd_addr [NDUT];
  logic [31:0] last_wb_addr [NDUT];
  logic [255:0] last_wb_data[NDUT];
  logic [7:0]  op_log       [NDUT];
  bit          both_seen;

  int checks;
  int passes;

  function automatic logic [255:0] line_data(input logic [31:0] a);
    logic [255:0] l;
    for (int w = 0; w < 8; w++) l[w*32 +: 32] = {a[31:5], 3'(w), 2'b00} ^ 32'hC0DE_0000;
    return l;
  endfunction

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    localparam int unsigned W = (g == 0) ? 4 : ((g == 1) ? 2 : 8);

    param_wb_cache #(.WAYS(W), .SETS(16)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .ufp_addr  (ufp_addr[g]),
      .ufp_rmask (ufp_rmask[g]),
      .ufp_wmask (ufp_wmask[g]),
      .ufp_wdata (ufp_wdata[g]),
      .ufp_rdata (ufp_rdata[g]),
      .ufp_resp  (ufp_resp[g]),
      .dfp_addr  (dfp_addr[g]),
      .dfp_read  (dfp_read[g]),
      .dfp_write (dfp_write[g]),
      .dfp_wdata (dfp_wdata[g]),
      .dfp_rdata (dfp_rdata[g]),
      .dfp_resp  (dfp_resp[g])
    );

    // Memory model: answers after MEM_LAT cycles of a held request, logs every transfer.
    always @(negedge clk) begin
      if (resp_en[g]) begin
        if (dfp_read[g] && dfp_write[g]) both_seen = 1'b1;
        if (dfp_resp[g]) begin
          dfp_resp[g] = 1'b0;
          lat_cnt[g]  = 0;
        end else if (dfp_read[g] || dfp_write[g]) begin
          lat_cnt[g]++;
          if (lat_cnt[g] == MEM_LAT) begin
            lat_cnt[g]  = 0;
            dfp_resp[g] = 1'b1;
            if (dfp_write[g]) begin
              wr_cnt[g]++;
              last_wb_addr[g] = dfp_addr[g];
              last_wb_data[g] = dfp_wdata[g];
              op_log[g]       = {op_log[g][5:0], 2'd2};
            end else begin
              rd_cnt[g]++;
              last_rd_addr[g] = dfp_addr[g];
              dfp_rdata[g]    = line_data(dfp_addr[g]);
              op_log[g]       = {op_log[g][5:0], 2'd1};
            end
          end
        end else begin
          lat_cnt[g] = 0;
        end
      end
    end
  end

  task automatic do_req(input int d, input logic [31:0] a, input logic [3:0] rm,
                        input logic [3:0] wm, input logic [31:0] wd,
                        output logic [31:0] rd, output int lat);
    bit done;
    @(negedge clk);
    ufp_addr[d]  = a;
    ufp_rmask[d] = rm;
    ufp_wmask[d] = wm;
    ufp_wdata[d] = wd;
    @(posedge clk);
    lat  = 0;
    done = 1'b0;
    rd   = 'x;
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge clk);
      if (i == 0) begin
        ufp_rmask[d] = '0;
        ufp_wmask[d] = '0;
      end
      lat++;
      if (ufp_resp[d]) begin
        done = 1'b1;
        rd   = ufp_rdata[d];
      end
    end
    if (!done) begin
      checks++;
      $display("FAIL req_timeout dut%0d addr %h: no ufp_resp within 60 cycles", d, a);
      lat = -1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int d = 0; d < NDUT; d++) begin
      ufp_addr[d] = '0; ufp_rmask[d] = '0; ufp_wmask[d] = '0; ufp_wdata[d] = '0;
      dfp_rdata[d] = '0; dfp_resp[d] = 1'b0; resp_en[d] = 1'b1;
      op_log[d] = '0;
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < NDUT; d++) begin
      checks++;
      if ({ufp_resp[d], dfp_read[d], dfp_write[d]} !== 3'b000)
        $display("FAIL reset_outputs dut%0d: resp/read/write %b want 000", d,
                 {ufp_resp[d], dfp_read[d], dfp_write[d]});
      else passes++;
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_cold_read();
    logic [31:0] rd; int lat; int rd0;
    rd0 = rd_cnt[0];
    do_req(0, 32'h40, 4'hF, 4'h0, '0, rd, lat);
    checks++;
    if (rd_cnt[0] !== rd0 + 1) $display("FAIL cold_fill_count: got %0d want %0d", rd_cnt[0], rd0 + 1);
    else passes++;
    checks++;
    if (last_rd_addr[0] !== 32'h40) $display("FAIL cold_fill_addr: got %h want 00000040", last_rd_addr[0]);
    else passes++;
    checks++;
    if (rd !== 32'hC0DE_0040) $display("FAIL cold_rdata: got %h want c0de0040", rd);
    else passes++;
    do_req(0, 32'h40, 4'hF, 4'h0, '0, rd, lat);
    checks++;
    if (lat !== 1) $display("FAIL repeat_hit_latency: got %0d want 1", lat);
    else passes++;
    checks++;
    if (rd_cnt[0] !== rd0 + 1) $display("FAIL repeat_no_dfp: reads %0d want %0d", rd_cnt[0], rd0 + 1);
    else passes++;
  endtask

  task automatic test_write_hit();
    logic [31:0] rd; int lat; int rd0;
    rd0 = rd_cnt[0];
    do_req(0, 32'h44, 4'h0, 4'b0011, 32'hAABB_CCDD, rd, lat);
    checks++;
    if (lat !== 1) $display("FAIL write_hit_latency: got %0d want 1", lat);
    else passes++;
    do_req(0, 32'h44, 4'hF, 4'h0, '0, rd, lat);
    checks++;
    if (rd !== 32'hC0DE_CCDD) $display("FAIL write_merge_rdata: got %h want c0deccdd", rd);
    else passes++;
    checks++;
    if (rd_cnt[0] !== rd0 || wr_cnt[0] !== 0)
      $display("FAIL write_hit_no_dfp: reads %0d writes %0d want %0d 0", rd_cnt[0], wr_cnt[0], rd0);
    else passes++;
  endtask

  task automatic test_evict_dirty();
    logic [31:0] rd; int lat; int rd0;
    logic [255:0] exp_line;
    for (int t = 1; t < 4; t++) do_req(0, (t << 9) | 32'h40, 4'hF, 4'h0, '0, rd, lat);
    rd0 = rd_cnt[0];
    do_req(0, 32'h840, 4'hF, 4'h0, '0, rd, lat);
    exp_line = line_data(32'h40);
    exp_line[63:32] = 32'hC0DE_CCDD;
    checks++;
    if (wr_cnt[0] !== 1) $display("FAIL evict_wb_count: got %0d want 1", wr_cnt[0]);
    else passes++;
    checks++;
    if (last_wb_addr[0] !== 32'h40) $display("FAIL evict_wb_addr: got %h want 00000040", last_wb_addr[0]);
    else passes++;
    checks++;
    if (last_wb_data[0] !== exp_line) $display("FAIL evict_wb_data: got %h want %h", last_wb_data[0], exp_line);
    else passes++;
    checks++;
    if (op_log[0][3:0] !== 4'b1001) $display("FAIL evict_order: last ops %b want 1001 (write then read)", op_log[0][3:0]);
    else passes++;
    checks++;
    if (rd !== 32'hC0DE_0840 || rd_cnt[0] !== rd0 + 1)
      $display("FAIL evict_fill: rdata %h reads %0d want c0de0840 %0d", rd, rd_cnt[0], rd0 + 1);
    else passes++;
    do_req(0, 32'h240, 4'hF, 4'h0, '0, rd, lat);
    checks++;
    if (lat !== 1 || rd !== 32'hC0DE_0240) $display("FAIL evict_keeps_way1: lat %0d rdata %h want 1 c0de0240", lat, rd);
    else passes++;
  endtask

  task automatic test_two_way();
    logic [31:0] rd; int lat; int rd0;
    do_req(1, 32'h40,  4'hF, 4'h0, '0, rd, lat);
    do_req(1, 32'h240, 4'hF, 4'h0, '0, rd, lat);
    do_req(1, 32'h40,  4'hF, 4'h0, '0, rd, lat);
    checks++;
    if (lat !== 1) $display("FAIL w2_rehit_latency: got %0d want 1", lat);
    else passes++;
    do_req(1, 32'h440, 4'hF, 4'h0, '0, rd, lat);
    checks++;
    if (rd_cnt[1] !== 3 || wr_cnt[1] !== 0 || rd !== 32'hC0DE_0440)
      $display("FAIL w2_extra_fill: reads %0d writes %0d rdata %h want 3 0 c0de0440", rd_cnt[1], wr_cnt[1], rd);
    else passes++;
    do_req(1, 32'h40, 4'hF, 4'h0, '0, rd, lat);
    checks++;
    if (lat !== 1 || rd !== 32'hC0DE_0040) $display("FAIL w2_keeps_way0: lat %0d rdata %h want 1 c0de0040", lat, rd);
    else passes++;
    rd0 = rd_cnt[1];
    do_req(1, 32'h240, 4'hF, 4'h0, '0, rd, lat);
    checks++;
    if (rd_cnt[1] !== rd0 + 1) $display("FAIL w2_victim_way1: reads %0d want %0d", rd_cnt[1], rd0 + 1);
    else passes++;
  endtask

  task automatic test_eight_way();
    logic [31:0] rd; int lat; int rd0;
    for (int t = 0; t < 8; t++) do_req(2, (t << 9) | 32'h40, 4'hF, 4'h0, '0, rd, lat);
    checks++;
    if (rd_cnt[2] !== 8) $display("FAIL w8_fill_count: got %0d want 8", rd_cnt[2]);
    else passes++;
    do_req(2, 32'h40, 4'hF, 4'h0, '0, rd, lat);
    do_req(2, 32'h1040, 4'hF, 4'h0, '0, rd, lat);
    checks++;
    if (rd_cnt[2] !== 9 || rd !== 32'hC0DE_1040)
      $display("FAIL w8_extra_fill: reads %0d rdata %h want 9 c0de1040", rd_cnt[2], rd);
    else passes++;
    for (int t = 0; t < 8; t++) begin
      if (t != 4) begin
        do_req(2, (t << 9) | 32'h40, 4'hF, 4'h0, '0, rd, lat);
        checks++;
        if (lat !== 1 || rd !== (((t << 9) | 32'h40) ^ 32'hC0DE_0000))
          $display("FAIL w8_retained_tag%0d: lat %0d rdata %h", t, lat, rd);
        else passes++;
      end
    end
    rd0 = rd_cnt[2];
    do_req(2, 32'h840, 4'hF, 4'h0, '0, rd, lat);
    checks++;
    if (rd_cnt[2] !== rd0 + 1) $display("FAIL w8_victim_way4: reads %0d want %0d", rd_cnt[2], rd0 + 1);
    else passes++;
  endtask

  task automatic test_reset_alloc();
    logic [31:0] rd; int lat; int rd0; bit seen;
    resp_en[0] = 1'b0;
    @(negedge clk);
    ufp_addr[0] = 32'hA40; ufp_rmask[0] = 4'hF;
    @(posedge clk);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      ufp_rmask[0] = '0;
      if (dfp_read[0]) seen = 1'b1;
    end
    checks++;
    if (!seen) $display("FAIL rst_alloc_reach: dfp_read %b want 1", dfp_read[0]);
    else passes++;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({dfp_read[0], ufp_resp[0]} !== 2'b00)
      $display("FAIL rst_alloc_drop: read/resp %b want 00", {dfp_read[0], ufp_resp[0]});
    else passes++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    dfp_resp[0] = 1'b0; lat_cnt[0] = 0; resp_en[0] = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (ufp_resp[0] !== 1'b0) $display("FAIL rst_alloc_no_resp: ufp_resp %b want 0", ufp_resp[0]);
    else passes++;
    rd0 = rd_cnt[0];
    do_req(0, 32'hA40, 4'hF, 4'h0, '0, rd, lat);
    checks++;
    if (rd_cnt[0] !== rd0 + 1 || rd !== 32'hC0DE_0A40)
      $display("FAIL rst_alloc_remiss: reads %0d rdata %h want %0d c0de0a40", rd_cnt[0], rd, rd0 + 1);
    else passes++;
  endtask

  task automatic test_idle_resp();
    logic [31:0] rd; int lat; int rd0;
    do_req(0, 32'h40, 4'hF, 4'h0, '0, rd, lat);
    rd0 = rd_cnt[0];
    resp_en[0] = 1'b0;
    @(negedge clk);
    dfp_rdata[0] = '1;
    dfp_resp[0]  = 1'b1;
    @(negedge clk);
    checks++;
    if ({ufp_resp[0], dfp_read[0], dfp_write[0]} !== 3'b000)
      $display("FAIL idle_resp_outputs: resp/read/write %b want 000", {ufp_resp[0], dfp_read[0], dfp_write[0]});
    else passes++;
    dfp_resp[0] = 1'b0;
    resp_en[0]  = 1'b1;
    do_req(0, 32'h40, 4'hF, 4'h0, '0, rd, lat);
    checks++;
    if (lat !== 1 || rd !== 32'hC0DE_0040 || rd_cnt[0] !== rd0)
      $display("FAIL idle_resp_no_write: lat %0d rdata %h reads %0d want 1 c0de0040 %0d", lat, rd, rd_cnt[0], rd0);
    else passes++;
  endtask

  initial begin
    checks    = 0;
    passes    = 0;
    both_seen = 1'b0;
    test_reset();
    test_cold_read();
    test_write_hit();
    test_evict_dirty();
    test_two_way();
    test_eight_way();
    test_reset_alloc();
    test_idle_resp();
    checks++;
    if (both_seen !== 1'b0) $display("FAIL dfp_exclusive: read and write seen together");
    else passes++;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
